cpu_run_sequencer: RTL and testbench

//  Synthesizable run-control sequencer for the CPU core. It launches a programmed list of program start

---
 rtl/cpu_run_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_cpu_run_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer: runs a list of CPU programs back to back, timing
// each run and aborting the sequence if a run never signals done.
//
// Ports
//   clock_i        : system clock, rising edge
//   reset_i        : asynchronous, active-high reset
//   go_i           : begin a sequence (sampled in IDLE only)
//   run_count_i    : number of runs, clamped to MAX_RUNS, latched on go
//   run_addr_i     : run k start address at [k*ADDR_W +: ADDR_W]
//   done_i         : CPU done level; only rising edges complete a run
//   start_o        : CPU start pulse, START_LEN cycles per run
//   start_addr_o   : CPU start address for the current run
//   busy_o         : high whenever the sequencer is not idle
//   run_idx_o      : index of the current or last run
//   cycles_o       : cycle count of the last completed run
//   cycles_valid_o : one-cycle pulse when cycles_o updates
//   total_cycles_o : saturating sum of run cycle counts
//   timeout_o      : sticky, sequence aborted by the watchdog
//   all_done_o     : one-cycle pulse at the end of a sequence
module cpu_run_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int MAX_RUNS    = 4,
    parameter int CNT_W       = 15,
    parameter int TOT_W       = 20,
    parameter int START_LEN   = 1,
    parameter int TIMEOUT_CYC = 20000,
    localparam int RC_W       = $clog2(MAX_RUNS + 1),
    localparam int IDX_W      = (MAX_RUNS > 1) ? $clog2(MAX_RUNS) : 1
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       go_i,
    input  logic [RC_W-1:0]            run_count_i,
    input  logic [MAX_RUNS*ADDR_W-1:0] run_addr_i,
    input  logic                       done_i,
    output logic                       start_o,
    output logic [ADDR_W-1:0]          start_addr_o,
    output logic                       busy_o,
    output logic [IDX_W-1:0]           run_idx_o,
    output logic [CNT_W-1:0]           cycles_o,
    output logic                       cycles_valid_o,
    output logic [TOT_W-1:0]           total_cycles_o,
    output logic                       timeout_o,
    output logic                       all_done_o
);

    localparam int SL_W  = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam int SUM_W = ((TOT_W > CNT_W) ? TOT_W : CNT_W) + 1;

    // A limit the saturating counter can never reach would disable
    // the watchdog anyway; gating it avoids a truncated compare.
    localparam bit WD_EN =
        (TIMEOUT_CYC > 0) &&
        ((CNT_W >= 31) ? 1'b1 : (TIMEOUT_CYC < (2 ** CNT_W)));

    localparam logic [CNT_W:0]      WD_LIM   = (CNT_W + 1)'(TIMEOUT_CYC);
    localparam logic [SUM_W-1:0]    TOT_MAX  =
        {{(SUM_W - TOT_W){1'b0}}, {TOT_W{1'b1}}};
    localparam logic [RC_W-1:0]     RUNS_MAX = RC_W'(MAX_RUNS);
    localparam logic [SL_W-1:0]     SL_LAST  = SL_W'(START_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_FINISH
    } state_e;

    state_e                     state_q, state_d;
    logic [RC_W-1:0]            count_q, count_d;
    logic [MAX_RUNS*ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [SL_W-1:0]            slen_q, slen_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       done_q;
    logic                       start_q, start_d;
    logic [ADDR_W-1:0]          saddr_q, saddr_d;
    logic                       busy_q, busy_d;
    logic [CNT_W-1:0]           cycles_q, cycles_d;
    logic                       cvalid_q, cvalid_d;
    logic [TOT_W-1:0]           total_q, total_d;
    logic                       timeout_q, timeout_d;
    logic                       alldone_q, alldone_d;

    logic                       done_ev;
    logic [CNT_W-1:0]           cnt_inc;
    logic [SUM_W-1:0]           sum;
    logic [TOT_W-1:0]           tot_sat;
    logic [RC_W-1:0]            run_clamp;
    logic [RC_W-1:0]            idx_ext;
    logic                       last_run;
    logic [IDX_W-1:0]           idx_nxt;
    logic                       wd_hit;

    // A done level left high by the previous run must not complete
    // the next one, so only a fresh rising edge counts.
    assign done_ev   = done_i & ~done_q;

    // Counter value including the current cycle, saturating.
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    assign sum       = SUM_W'(total_q) + SUM_W'(cnt_inc);
    assign tot_sat   = (sum > TOT_MAX) ? {TOT_W{1'b1}}
                                       : sum[TOT_W-1:0];

    assign run_clamp = (run_count_i > RUNS_MAX) ? RUNS_MAX
                                                : run_count_i;

    assign idx_ext   = RC_W'(idx_q);
    assign last_run  = (idx_ext + RC_W'(1)) == count_q;
    assign idx_nxt   = idx_q + IDX_W'(1);

    assign wd_hit    = WD_EN && ({1'b0, cnt_inc} >= WD_LIM);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        slen_d    = slen_q;
        cnt_d     = cnt_q;
        saddr_d   = saddr_q;
        cycles_d  = cycles_q;
        cvalid_d  = 1'b0;
        total_d   = total_q;
        timeout_d = timeout_q;
        alldone_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    count_d   = run_clamp;
                    addr_d    = run_addr_i;
                    idx_d     = '0;
                    total_d   = '0;
                    timeout_d = 1'b0;
                    slen_d    = '0;
                    cnt_d     = '0;
                    if (run_clamp != '0) begin
                        state_d = S_START;
                        saddr_d = run_addr_i[ADDR_W-1:0];
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end

            S_START: begin
                cnt_d = '0;
                if (slen_q == SL_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    slen_d = slen_q + SL_W'(1);
                end
            end

            S_WAIT: begin
                if (done_ev) begin
                    // Done beats a watchdog hit in the same cycle.
                    cycles_d = cnt_inc;
                    cvalid_d = 1'b1;
                    total_d  = tot_sat;
                    if (last_run) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_START;
                        idx_d   = idx_nxt;
                        slen_d  = '0;
                        saddr_d = addr_q[idx_nxt*ADDR_W +: ADDR_W];
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (wd_hit) begin
                        timeout_d = 1'b1;
                        state_d   = S_FINISH;
                    end
                end
            end

            S_FINISH: begin
                alldone_d = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Decoded from the next state so the registered outputs
        // line up with the state they describe.
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            slen_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            saddr_q   <= '0;
            busy_q    <= 1'b0;
            cycles_q  <= '0;
            cvalid_q  <= 1'b0;
            total_q   <= '0;
            timeout_q <= 1'b0;
            alldone_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            slen_q    <= slen_d;
            cnt_q     <= cnt_d;
            done_q    <= done_i;
            start_q   <= start_d;
            saddr_q   <= saddr_d;
            busy_q    <= busy_d;
            cycles_q  <= cycles_d;
            cvalid_q  <= cvalid_d;
            total_q   <= total_d;
            timeout_q <= timeout_d;
            alldone_q <= alldone_d;
        end
    end

    assign start_o        = start_q;
    assign start_addr_o   = saddr_q;
    assign busy_o         = busy_q;
    assign run_idx_o      = idx_q;
    assign cycles_o       = cycles_q;
    assign cycles_valid_o = cvalid_q;
    assign total_cycles_o = total_q;
    assign timeout_o      = timeout_q;
    assign all_done_o     = alldone_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// tb_cpu_run_sequencer: directed bench for cpu_run_sequencer.
// Instance 0 uses default parameters; instance 1 has a 100-cycle watchdog and narrow counters.
module tb_cpu_run_sequencer;

    localparam int NL = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [2:0] run_count = '0;
    logic [31:0] run_addr = '0;
    logic       gov [2] = '{1'b0, 1'b0};
    logic       dn  [2] = '{1'b0, 1'b0};

    logic        start_m, busy_m, cv_m, to_m, ad_m;
    logic [7:0]  saddr_m;
    logic [1:0]  idx_m;
    logic [14:0] cyc_m;
    logic [19:0] tot_m;

    logic        start_w, busy_w, cv_w, to_w, ad_w;
    logic [7:0]  saddr_w;
    logic [1:0]  idx_w;
    logic [6:0]  cyc_w;
    logic [7:0]  tot_w;

    cpu_run_sequencer u_dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .go_i           (gov[0]),
        .run_count_i    (run_count),
        .run_addr_i     (run_addr),
        .done_i         (dn[0]),
        .start_o        (start_m),
        .start_addr_o   (saddr_m),
        .busy_o         (busy_m),
        .run_idx_o      (idx_m),
        .cycles_o       (cyc_m),
        .cycles_valid_o (cv_m),
        .total_cycles_o (tot_m),
        .timeout_o      (to_m),
        .all_done_o     (ad_m)
    );

    cpu_run_sequencer #(
        .CNT_W       (7),
        .TOT_W       (8),
        .TIMEOUT_CYC (100)
    ) u_wd (
        .clock_i        (clk),
        .reset_i        (rst),
        .go_i           (gov[1]),
        .run_count_i    (run_count),
        .run_addr_i     (run_addr),
        .done_i         (dn[1]),
        .start_o        (start_w),
        .start_addr_o   (saddr_w),
        .busy_o         (busy_w),
        .run_idx_o      (idx_w),
        .cycles_o       (cyc_w),
        .cycles_valid_o (cv_w),
        .total_cycles_o (tot_w),
        .timeout_o      (to_w),
        .all_done_o     (ad_w)
    );

    int ob_start [2], ob_addr [2], ob_busy [2], ob_cyc [2];
    int ob_cv [2], ob_tot [2], ob_to [2], ob_ad [2], ob_idx [2];

    always_comb begin
        ob_start[0] = int'(start_m);  ob_start[1] = int'(start_w);
        ob_addr[0]  = int'(saddr_m);  ob_addr[1]  = int'(saddr_w);
        ob_busy[0]  = int'(busy_m);   ob_busy[1]  = int'(busy_w);
        ob_cyc[0]   = int'(cyc_m);    ob_cyc[1]   = int'(cyc_w);
        ob_cv[0]    = int'(cv_m);     ob_cv[1]    = int'(cv_w);
        ob_tot[0]   = int'(tot_m);    ob_tot[1]   = int'(tot_w);
        ob_to[0]    = int'(to_m);     ob_to[1]    = int'(to_w);
        ob_ad[0]    = int'(ad_m);     ob_ad[1]    = int'(ad_w);
        ob_idx[0]   = int'(idx_m);    ob_idx[1]   = int'(idx_w);
    end

    // CPU model and monitor state
    int n_start [2], n_scyc [2], n_cv [2], n_ad [2];
    int addr_log [2][NL], cyc_log [2][NL], lat_tab [2][NL];
    bit stale [2];
    int fcnt [2], to_at [2];
    bit active [2], prev_st [2], prev_to [2];

    // CPU model: done rises lat cycles after start falls (lat 0 = never).
    // Normally done drops when start is seen; a stale run keeps the old
    // level through START and drops it two cycles into the wait.
    always @(negedge clk) begin
        int lat;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                dn[i]      = 1'b0;
                active[i]  = 1'b0;
                prev_st[i] = 1'b0;
                prev_to[i] = 1'b0;
                fcnt[i]    = 0;
            end else begin
                if (ob_start[i] != 0) begin
                    if (!prev_st[i]) begin
                        addr_log[i][n_start[i] % NL] = ob_addr[i];
                        n_start[i]++;
                    end
                    n_scyc[i]++;
                    if (!stale[i]) dn[i] = 1'b0;
                    active[i] = 1'b0;
                    fcnt[i]   = 0;
                end else if (prev_st[i]) begin
                    active[i] = 1'b1;
                    fcnt[i]   = 1;
                end else begin
                    fcnt[i]++;
                end
                if (active[i] && n_start[i] > 0) begin
                    lat = lat_tab[i][(n_start[i] - 1) % NL];
                    if (stale[i] && fcnt[i] == 2) dn[i] = 1'b0;
                    if (lat != 0 && fcnt[i] == lat) begin
                        dn[i]     = 1'b1;
                        active[i] = 1'b0;
                    end
                end
                if (ob_cv[i] != 0) begin
                    cyc_log[i][n_cv[i] % NL] = ob_cyc[i];
                    n_cv[i]++;
                end
                if (ob_ad[i] != 0) n_ad[i]++;
                if (ob_to[i] != 0 && !prev_to[i]) to_at[i] = fcnt[i];
                prev_st[i] = (ob_start[i] != 0);
                prev_to[i] = (ob_to[i] != 0);
            end
        end
    end

    typedef struct packed {
        int               inst;
        int               cnt;
        logic [3:0][7:0]  addr;
        logic [3:0][15:0] lat;
        logic             stl;
        int               exp_starts;
        int               exp_ncv;
        logic [3:0][15:0] exp_cyc;
        int               exp_tot;
        int               exp_to;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input int inst, input int cnt,
        input int a0, input int a1, input int a2, input int a3,
        input int l0, input int l1, input int l2, input int l3,
        input int stl, input int es, input int ncv,
        input int c0, input int c1, input int c2, input int c3,
        input int tot, input int to);
        vec_t v;
        v = '0;
        v.inst = inst;
        v.cnt  = cnt;
        v.addr[0] = 8'(a0); v.addr[1] = 8'(a1);
        v.addr[2] = 8'(a2); v.addr[3] = 8'(a3);
        v.lat[0] = 16'(l0); v.lat[1] = 16'(l1);
        v.lat[2] = 16'(l2); v.lat[3] = 16'(l3);
        v.stl = (stl != 0);
        v.exp_starts = es;
        v.exp_ncv = ncv;
        v.exp_cyc[0] = 16'(c0); v.exp_cyc[1] = 16'(c1);
        v.exp_cyc[2] = 16'(c2); v.exp_cyc[3] = 16'(c3);
        v.exp_tot = tot;
        v.exp_to  = to;
        return v;
    endfunction

    task automatic pulse_go(input int i);
        @(negedge clk);
        gov[i] = 1'b1;
        @(negedge clk);
        gov[i] = 1'b0;
    endtask

    task automatic wait_all_done(input int i, input int base,
                                 input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            #1;
            if (n_ad[i] > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_row(input vec_t v, input int r);
        int i, b_st, b_sc, b_cv, b_ad, exp_idx;
        bit ok;
        i    = v.inst;
        b_st = n_start[i];
        b_sc = n_scyc[i];
        b_cv = n_cv[i];
        b_ad = n_ad[i];
        stale[i] = v.stl;
        for (int k = 0; k < 4; k++)
            lat_tab[i][(b_st + k) % NL] = int'(v.lat[k]);
        run_count = 3'(v.cnt);
        run_addr  = v.addr;
        pulse_go(i);
        wait_all_done(i, b_ad, 3000, ok);
        chk($sformatf("row%0d_finished", r), int'(ok), 1);
        repeat (3) @(negedge clk);
        #1;
        chk($sformatf("row%0d_starts", r), n_start[i] - b_st, v.exp_starts);
        chk($sformatf("row%0d_start_cyc", r), n_scyc[i] - b_sc,
            v.exp_starts);
        for (int k = 0; k < v.exp_starts; k++)
            chk($sformatf("row%0d_addr%0d", r, k),
                addr_log[i][(b_st + k) % NL], int'(v.addr[k]));
        chk($sformatf("row%0d_ncv", r), n_cv[i] - b_cv, v.exp_ncv);
        for (int k = 0; k < v.exp_ncv; k++)
            chk($sformatf("row%0d_cycles%0d", r, k),
                cyc_log[i][(b_cv + k) % NL], int'(v.exp_cyc[k]));
        chk($sformatf("row%0d_total", r), ob_tot[i], v.exp_tot);
        chk($sformatf("row%0d_timeout", r), ob_to[i], v.exp_to);
        if (v.exp_to != 0)
            chk($sformatf("row%0d_timeout_at", r), to_at[i], 101);
        chk($sformatf("row%0d_all_done", r), n_ad[i] - b_ad, 1);
        chk($sformatf("row%0d_busy", r), ob_busy[i], 0);
        exp_idx = (v.exp_starts > 0) ? v.exp_starts - 1 : 0;
        chk($sformatf("row%0d_idx", r), ob_idx[i], exp_idx);
    endtask

    vec_t tab [7];

    initial begin
        #500000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int b_st, b_ad;
        bit ok;

        //          inst cnt addr0..3        lat0..3        stl es ncv cyc0..3       tot to
        tab[0] = mk(0, 1, 93, 0, 0, 0,      50, 0, 0, 0,    0, 1, 1, 50, 0, 0, 0,   50, 0);
        tab[1] = mk(0, 3, 93, 93, 138, 0,   50, 50, 120, 0, 0, 3, 3, 50, 50, 120, 0, 220, 0);
        tab[2] = mk(0, 1, 7, 0, 0, 0,       30, 0, 0, 0,    1, 1, 1, 30, 0, 0, 0,   30, 0);
        tab[3] = mk(0, 6, 1, 2, 3, 4,       3, 1, 2, 5,     0, 4, 4, 3, 1, 2, 5,    11, 0);
        tab[4] = mk(1, 2, 5, 6, 0, 0,       0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0,    0, 1);
        tab[5] = mk(1, 1, 9, 0, 0, 0,       100, 0, 0, 0,   0, 1, 1, 100, 0, 0, 0,  100, 0);
        tab[6] = mk(1, 3, 10, 11, 12, 0,    90, 90, 90, 0,  0, 3, 3, 90, 90, 90, 0, 255, 0);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_start", ob_start[0], 0);
        chk("reset_busy", ob_busy[0], 0);
        chk("reset_addr", ob_addr[0], 0);
        chk("reset_cycles", ob_cyc[0], 0);
        chk("reset_total", ob_tot[0], 0);
        chk("reset_timeout", ob_to[0], 0);
        chk("reset_all_done", ob_ad[0], 0);
        rst = 1'b0;

        for (int r = 0; r < 7; r++)
            run_row(tab[r], r);

        // single run timing, plus a go during busy that must not queue
        b_st = n_start[0];
        b_ad = n_ad[0];
        stale[0] = 1'b0;
        lat_tab[0][b_st % NL] = 40;
        run_count = 3'd1;
        run_addr  = 32'h0000_00C8;
        pulse_go(0);
        #1;
        chk("go_start_hi", ob_start[0], 1);
        chk("go_start_addr", ob_addr[0], 200);
        chk("go_busy", ob_busy[0], 1);
        @(negedge clk);
        #1;
        chk("go_start_lo", ob_start[0], 0);
        chk("go_addr_held", ob_addr[0], 200);
        repeat (8) @(negedge clk);
        run_count = 3'd2;
        run_addr  = 32'h0000_3344;
        gov[0] = 1'b1;
        @(negedge clk);
        gov[0] = 1'b0;
        wait_all_done(0, b_ad, 500, ok);
        chk("busy_go_finished", int'(ok), 1);
        chk("busy_go_cycles", ob_cyc[0], 40);
        repeat (10) @(negedge clk);
        #1;
        chk("busy_go_starts", n_start[0] - b_st, 1);
        chk("busy_go_all_done", n_ad[0] - b_ad, 1);
        chk("busy_go_idle", ob_busy[0], 0);
        chk("idle_addr_held", ob_addr[0], 200);

        // zero-length sequence: all_done two cycles after go
        b_st = n_start[0];
        run_count = 3'd0;
        @(negedge clk);
        gov[0] = 1'b1;
        @(negedge clk);
        gov[0] = 1'b0;
        #1;
        chk("zero_ad_n1", ob_ad[0], 0);
        chk("zero_busy_n1", ob_busy[0], 1);
        @(negedge clk);
        #1;
        chk("zero_ad_n2", ob_ad[0], 1);
        chk("zero_busy_n2", ob_busy[0], 0);
        @(negedge clk);
        #1;
        chk("zero_ad_n3", ob_ad[0], 0);
        chk("zero_starts", n_start[0] - b_st, 0);

        // reset in the middle of the second run's wait
        b_st = n_start[0];
        stale[0] = 1'b0;
        lat_tab[0][b_st % NL] = 20;
        lat_tab[0][(b_st + 1) % NL] = 200;
        run_count = 3'd2;
        run_addr  = 32'h0000_2C21;
        pulse_go(0);
        repeat (40) @(negedge clk);
        #1;
        chk("mid_busy", ob_busy[0], 1);
        chk("mid_idx", ob_idx[0], 1);
        chk("mid_cycles", ob_cyc[0], 20);
        chk("mid_total", ob_tot[0], 20);
        rst = 1'b1;
        #1;
        chk("rst_start", ob_start[0], 0);
        chk("rst_busy", ob_busy[0], 0);
        chk("rst_cycles", ob_cyc[0], 0);
        chk("rst_total", ob_tot[0], 0);
        chk("rst_idx", ob_idx[0], 0);
        chk("rst_addr", ob_addr[0], 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        run_row(mk(0, 1, 77, 0, 0, 0, 10, 0, 0, 0,
                   0, 1, 1, 10, 0, 0, 0, 10, 0), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
